// File: rtl/tuner_pkg.sv
// Shared constants, lag table, FSM encoding and the 32-bit saturation helper
// for the tuner autocorrelation front end.
package tuner_pkg;

  localparam int FRAME_LEN = 65536;
  localparam int NUM_LAGS  = 16;
  localparam int BUF_DEPTH = 256;
  localparam int ACC_W     = 48;

  // Pitch-search lags in samples; all nonzero so a sample never pairs with itself.
  localparam logic [7:0] LAG [NUM_LAGS] = '{
    8'd1,  8'd2,  8'd3,  8'd5,  8'd7,  8'd10, 8'd14, 8'd19,
    8'd25, 8'd32, 8'd40, 8'd49, 8'd59, 8'd70, 8'd82, 8'd95
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DUMP  = 2'd3
  } acdb_state_e;

  // Clamp a signed accumulator-width value into signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-32:0] hi;
    hi = v[ACC_W-1:31];
    if ((hi == {(ACC_W-31){1'b0}}) || (hi == {(ACC_W-31){1'b1}})) begin
      sat32 = v[31:0];
    end else if (v[ACC_W-1]) begin
      sat32 = 32'h8000_0000;
    end else begin
      sat32 = 32'h7FFF_FFFF;
    end
  endfunction

endpackage

// File: rtl/sample_ringbuf.sv
// 256x16 circular sample history: one write port at the write pointer and one
// combinational read port addressed by lag behind that pointer.
module sample_ringbuf
  import tuner_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               wr_en,
  input  logic signed [15:0] wr_data,
  input  logic               ptr_adv,
  input  logic [7:0]         rd_lag,
  output logic signed [15:0] rd_data
);

  logic signed [15:0] mem_r [BUF_DEPTH];
  logic [7:0]         wr_ptr_r;
  logic [7:0]         rd_addr_s;

  assign rd_addr_s = wr_ptr_r - rd_lag;
  assign rd_data   = mem_r[rd_addr_s];

  // Storage and write pointer; unwritten entries read as zero after reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= 16'sd0;
      end
      wr_ptr_r <= 8'd0;
    end else begin
      if (wr_en) begin
        mem_r[wr_ptr_r] <= wr_data;
      end
      if (ptr_adv) begin
        wr_ptr_r <= wr_ptr_r + 8'd1;
      end
    end
  end

endmodule

// File: rtl/autocorr_delaybuff.sv
// Autocorrelation front end: per-sample 16-lag MAC over a frame, then a tagged
// result stream {lag_idx, sat32(acc >>> SHIFT)} for the peak comparator.
module autocorr_delaybuff
  import tuner_pkg::*;
#(
  parameter int SHIFT         = 16,
  parameter int FRAME_SAMPLES = FRAME_LEN
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               sample_valid_i,
  input  logic signed [15:0] sample_i,
  output logic               sample_ready_o,
  output logic               overrun_o,
  output logic [17:0]        counter_o,
  output logic               db_valid_o,
  output logic [35:0]        delaybuff_o,
  output logic               frame_done_o
);

  acdb_state_e        state_r, state_s;
  logic [3:0]         k_r;
  logic signed [15:0] x_n_r;
  logic [17:0]        counter_r;
  logic               last_r;
  logic signed [ACC_W-1:0] acc_r [NUM_LAGS];
  logic [35:0]        db_r;
  logic               db_valid_r;
  logic               frame_done_r;
  logic               overrun_r;

  logic               accept_s;
  logic               ptr_adv_s;
  logic               dump_load_s;
  logic [3:0]         dump_idx_s;
  logic signed [15:0] partner_s;
  logic signed [31:0] prod_s;
  logic signed [ACC_W-1:0] shifted_s;

  assign accept_s  = sample_valid_i && (state_r == ST_IDLE);
  assign ptr_adv_s = (state_r == ST_MAC) && (k_r == 4'd15);
  assign prod_s    = x_n_r * partner_s;
  assign shifted_s = acc_r[dump_idx_s] >>> SHIFT;

  sample_ringbuf u_ringbuf (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .wr_en    (accept_s),
    .wr_data  (sample_i),
    .ptr_adv  (ptr_adv_s),
    .rd_lag   (LAG[k_r]),
    .rd_data  (partner_s)
  );

  // Next-state logic; also picks which accumulator the output register loads next.
  always_comb begin
    state_s     = state_r;
    dump_load_s = 1'b0;
    dump_idx_s  = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_MAC;
        else          state_s = ST_IDLE;
      end
      ST_MAC: begin
        if (k_r == 4'd15) state_s = last_r ? ST_CLEAR : ST_IDLE;
        else              state_s = ST_MAC;
      end
      ST_CLEAR: begin
        state_s     = ST_DUMP;
        dump_load_s = 1'b1;
        dump_idx_s  = 4'd0;
      end
      ST_DUMP: begin
        if (k_r == 4'd15) begin
          state_s = ST_IDLE;
        end else begin
          state_s     = ST_DUMP;
          dump_load_s = 1'b1;
          dump_idx_s  = k_r + 4'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_r <= ST_IDLE;
    else           state_r <= state_s;
  end

  // Lag index, latched sample and frame sample counter.
  // The final sample of a frame leaves the count at FRAME_SAMPLES-1 so that the
  // full count is visible only during CLEAR.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      k_r       <= 4'd0;
      x_n_r     <= 16'sd0;
      counter_r <= 18'd0;
      last_r    <= 1'b0;
    end else begin
      if ((state_r == ST_MAC) || (state_r == ST_DUMP)) k_r <= k_r + 4'd1;
      else                                             k_r <= 4'd0;
      if (accept_s) begin
        x_n_r <= sample_i;
        if (counter_r == 18'(FRAME_SAMPLES - 1)) last_r <= 1'b1;
        else                                     counter_r <= counter_r + 18'd1;
      end else if (ptr_adv_s && last_r) begin
        counter_r <= 18'(FRAME_SAMPLES);
        last_r    <= 1'b0;
      end else if (state_r == ST_CLEAR) begin
        counter_r <= 18'd0;
      end
    end
  end

  // Per-lag accumulators: MAC adds, a dump read clears the entry it reads.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_LAGS; i++) begin
        acc_r[i] <= {ACC_W{1'b0}};
      end
    end else if (state_r == ST_MAC) begin
      acc_r[k_r] <= acc_r[k_r] + {{(ACC_W-32){prod_s[31]}}, prod_s};
    end else if (dump_load_s) begin
      acc_r[dump_idx_s] <= {ACC_W{1'b0}};
    end
  end

  // Registered result stream and sticky overrun flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      db_r         <= 36'd0;
      db_valid_r   <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (dump_load_s) begin
        db_r         <= {dump_idx_s, sat32(shifted_s)};
        db_valid_r   <= 1'b1;
        frame_done_r <= (dump_idx_s == 4'd15);
      end else begin
        db_valid_r   <= 1'b0;
        frame_done_r <= 1'b0;
      end
      if (sample_valid_i && (state_r != ST_IDLE)) overrun_r <= 1'b1;
    end
  end

  assign sample_ready_o = (state_r == ST_IDLE);
  assign overrun_o      = overrun_r;
  assign counter_o      = counter_r;
  assign db_valid_o     = db_valid_r;
  assign delaybuff_o    = db_r;
  assign frame_done_o   = frame_done_r;

endmodule

// File: tb/tb_autocorr_delaybuff.sv
// Bench for autocorr_delaybuff: two instances (SHIFT=16 and SHIFT=0) on shared
// stimulus, scored against a sample-history autocorrelation model.
module tb_autocorr_delaybuff;

  localparam int FRAME = 128;
  localparam int NL    = 16;
  localparam int LAG_T [NL] = '{1, 2, 3, 5, 7, 10, 14, 19, 25, 32, 40, 49, 59, 70, 82, 95};

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_ni;
  logic        sample_valid_i;
  logic [15:0] sample_i;
  logic        rdy_a, rdy_b, ovr_a, ovr_b, dbv_a, dbv_b, fd_a, fd_b;
  logic [17:0] cnt_a, cnt_b;
  logic [35:0] db_a, db_b;

  autocorr_delaybuff #(.SHIFT(16), .FRAME_SAMPLES(FRAME)) u_s16 (
    .clk_i(clk_i), .reset_ni(reset_ni), .sample_valid_i(sample_valid_i),
    .sample_i(sample_i), .sample_ready_o(rdy_a), .overrun_o(ovr_a),
    .counter_o(cnt_a), .db_valid_o(dbv_a), .delaybuff_o(db_a), .frame_done_o(fd_a)
  );

  autocorr_delaybuff #(.SHIFT(0), .FRAME_SAMPLES(FRAME)) u_s0 (
    .clk_i(clk_i), .reset_ni(reset_ni), .sample_valid_i(sample_valid_i),
    .sample_i(sample_i), .sample_ready_o(rdy_b), .overrun_o(ovr_b),
    .counter_o(cnt_b), .db_valid_o(dbv_b), .delaybuff_o(db_b), .frame_done_o(fd_b)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [35:0] q16 [$];
  logic [35:0] q0  [$];
  longint      acc_m [NL];
  longint      hist [$];
  int          n_in_frame;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_sat(input longint v, input int sh);
    longint s;
    s = v >>> sh;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return 32'(s);
  endfunction

  task automatic model_reset();
    hist.delete();
    q16.delete();
    q0.delete();
    for (int k = 0; k < NL; k++) acc_m[k] = 0;
    n_in_frame = 0;
  endtask

  // Offer one sample when ready; the model and scoreboard are updated as it is driven.
  task automatic send(input int x);
    int t;
    logic [3:0] kk;
    t = 0;
    while (!rdy_a && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (!rdy_a) check("ready_timeout", rdy_a, 1'b1);
    sample_valid_i = 1'b1;
    sample_i = x[15:0];
    for (int k = 0; k < NL; k++) begin
      if (hist.size() >= LAG_T[k]) acc_m[k] += longint'(x) * hist[hist.size() - LAG_T[k]];
    end
    hist.push_back(longint'(x));
    n_in_frame++;
    if (n_in_frame == FRAME) begin
      for (int k = 0; k < NL; k++) begin
        kk = 4'(k);
        q16.push_back({kk, model_sat(acc_m[k], 16)});
        q0.push_back({kk, model_sat(acc_m[k], 0)});
        acc_m[k] = 0;
      end
      n_in_frame = 0;
    end
    @(posedge clk_i);
    #1 sample_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic hw_reset();
    reset_ni = 1'b0;
    sample_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    model_reset();
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (q16.size() == 0 && q0.size() == 0 && rdy_a) break;
      @(negedge clk_i);
    end
    check("drain", (q16.size() == 0) && (q0.size() == 0), 1'b1);
    check("cnt_after_frame", cnt_a, 18'd0);
  endtask

  // mode 1: DC 256, 2: constant 32767, 3: alternating +/-20000.
  task automatic run_frame(input int mode, input bit ovr);
    int x;
    for (int n = 0; n < FRAME; n++) begin
      case (mode)
        1:       x = 256;
        2:       x = 32767;
        default: x = (n % 2 == 0) ? 20000 : -20000;
      endcase
      send(x);
      if (ovr && n != FRAME - 1) begin
        sample_valid_i = 1'b1;
        sample_i = 16'h5A5A;
        repeat (8) @(negedge clk_i);
        sample_valid_i = 1'b0;
        if (n == 2) check("ovr_cnt", cnt_a, 18'd3);
      end
    end
    if (ovr) begin
      for (int t = 0; t < 60; t++) begin
        if (dbv_a) break;
        @(negedge clk_i);
      end
      sample_valid_i = 1'b1;
      repeat (5) @(negedge clk_i);
      sample_valid_i = 1'b0;
    end
  endtask

  // Scoreboard consumer for both instances.
  always @(negedge clk_i) begin
    if (reset_ni && dbv_a) begin
      if (q16.size() == 0) check("spurious16", dbv_a, 1'b0);
      else begin
        check("dump16", db_a, q16[0]);
        check("fdone16", fd_a, q16[0][35:32] == 4'd15);
        void'(q16.pop_front());
      end
    end
    if (reset_ni && dbv_b) begin
      if (q0.size() == 0) check("spurious0", dbv_b, 1'b0);
      else begin
        check("dump0", db_b, q0[0]);
        check("fdone0", fd_b, q0[0][35:32] == 4'd15);
        void'(q0.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low, clr, clr_at;
    reset_ni = 1'b0;
    sample_valid_i = 1'b0;
    sample_i = 16'd0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("rst_ready", rdy_a, 1'b1);
    check("rst_dbv", dbv_a, 1'b0);
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("idle_ready", {rdy_a, rdy_b}, 2'b11);
    check("idle_cnt", cnt_a, 18'd0);
    check("idle_db", {dbv_a, db_a, fd_a, ovr_a}, 39'd0);
    check("idle_db0", {dbv_b, db_b, fd_b, ovr_b}, 39'd0);

    // Single sample into zero buffer, then zeros: all results stay zero.
    send(100);
    n_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (!rdy_a) n_low++;
      @(negedge clk_i);
    end
    check("ready_low_cycles", n_low, 16);
    check("cnt_one", cnt_a, 18'd1);
    for (int n = 1; n < FRAME; n++) send(0);
    drain();
    check("no_overrun", ovr_a, 1'b0);

    // DC frame from reset: CLEAR cycle and results FRAME - LAG[k].
    hw_reset();
    for (int n = 0; n < FRAME - 1; n++) send(256);
    check("cnt_pre_final", cnt_a, 18'(FRAME - 1));
    send(256);
    clr = 0;
    clr_at = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (cnt_a == 18'(FRAME)) begin
        clr++;
        clr_at = i;
        check("clear_dbv", dbv_a, 1'b0);
      end
    end
    check("clear_cycles", clr, 1);
    check("clear_at", clr_at, 16);
    drain();

    // Positive then mixed-sign saturation.
    run_frame(2, 1'b0);
    drain();
    run_frame(3, 1'b0);
    drain();
    check("no_overrun2", ovr_b, 1'b0);

    // Overrun during MAC and DUMP.
    run_frame(1, 1'b1);
    drain();
    repeat (5) @(negedge clk_i);
    check("overrun_a", ovr_a, 1'b1);
    check("overrun_b", ovr_b, 1'b1);

    // Reset during DUMP k=5, then a clean DC frame.
    run_frame(1, 1'b0);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk_i);
      if (dbv_a && db_a[35:32] == 4'd5) break;
    end
    check("dump5_seen", {dbv_a, db_a[35:32]}, 5'h15);
    #2 reset_ni = 1'b0;
    #1 check("rst_dbv_now", {dbv_a, dbv_b}, 2'b00);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_dbv_hold", dbv_a, 1'b0);
    end
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("rst_overrun_clr", ovr_a, 1'b0);
    run_frame(1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/autocorr_delaybuff.md
# autocorr_delaybuff

Autocorrelation front end of the tuner datapath, directly upstream of the peak comparator. Each accepted audio sample is written into a 256-entry delay buffer and multiplied against 16 fixed lags; the 16 per-lag sums accumulate over a 65,536-sample frame. At frame end the block signals the frame boundary on `counter_o`, then streams all 16 results as tagged 36-bit words `{lag_idx, value}` with a valid strobe. The comparator consumes that stream to select the peak lag, which gives the pitch.

## Interface
- `SHIFT`, default 16: arithmetic right shift applied to each 48-bit accumulator before 32-bit saturation.
- `clk_i` in 1: the single clock.
- `reset_ni` in 1: asynchronous, active-low reset.
- `sample_valid_i` in 1: a sample is offered this cycle.
- `sample_i` in 16: signed audio sample.
- `sample_ready_o` out 1: high only in IDLE; a sample is accepted on `sample_valid_i & sample_ready_o`.
- `overrun_o` out 1: sticky; set when `sample_valid_i` is high while `sample_ready_o` is low. Cleared only by reset.
- `counter_o` out 18: samples accepted in the current frame, 0..65535. Equals 65536 for exactly one cycle, in CLEAR.
- `db_valid_o` out 1: `delaybuff_o` holds a result.
- `delaybuff_o` out 36: `[35:32]` = lag index k; `[31:0]` = sat32(acc[k] >>> SHIFT), two's complement.
- `frame_done_o` out 1: one-cycle pulse coincident with the k=15 result.

## Operation
- **Reset state:** all outputs 0 except `sample_ready_o`=1. State is IDLE. The delay buffer, write pointer, all accumulators and the counter are 0.
- **FSM states:** IDLE, MAC, CLEAR, DUMP.
- **IDLE:**
  - On accept, write `sample_i` at `wr_ptr`, latch it as x_n, increment `counter_o`.
  - Go to MAC with k=0.
- **MAC (16 cycles, k=0..15):**
  - Compute acc[k] += x_n * buf[(wr_ptr − LAG[k]) mod 256].
  - Product is a 32-bit signed value, sign-extended into the 48-bit accumulator.
  - After k=15, advance `wr_ptr` (wraps 255→0).
  - If 65536 samples have now been accepted this frame, go to CLEAR; otherwise go to IDLE.
- **CLEAR (1 cycle):** `counter_o`=65536, `db_valid_o`=0. This clears the downstream maximum. Go to DUMP with k=0.
- **DUMP (16 cycles, k=0..15):**
  - `db_valid_o`=1, `delaybuff_o`={k, sat32(acc[k] >>> SHIFT)}.
  - acc[k] is cleared in the same cycle.
  - Then go to IDLE with `counter_o`=0.
- **Saturation:**
  - A shifted value above 2^31−1 outputs 0x7FFF_FFFF.
  - A shifted value below −2^31 outputs 0x8000_0000.
- **Lag range:** LAG[k] is in 1..255. The current sample is never its own partner.
- **Warm-up:** buffer entries not yet written read as 0, so early products are 0.
- **Overrun:** a sample offered in MAC, CLEAR or DUMP is dropped. It is not counted, and `overrun_o` is set.
- **Asynchronous reset:**
  - Reset in any state, including mid-MAC or mid-DUMP, returns immediately to the reset state.
  - No partial stream completes; `db_valid_o` drops at once.

## Timing
- Sample accepted at the clock edge ending cycle T:
  - MAC occupies T+1..T+16, and acc[k] is updated at the end of cycle T+1+k.
  - `sample_ready_o` is low over T+1..T+16 and high again at T+17 for a non-final sample.
- Final sample of the frame:
  - CLEAR at T+17.
  - DUMP at T+18..T+33, with k=15 and `frame_done_o` at T+33.
  - IDLE and ready at T+34.
- **Minimum sample spacing:** 17 cycles; 34 cycles after the final sample of a frame.
- **Output registering:** `delaybuff_o` and `db_valid_o` are registered. `delaybuff_o` holds its last value when `db_valid_o` is low.

## Structure
- **Package `tuner_pkg`:**
  - `LAG[16]` table of 8-bit lags.
  - Constants: `FRAME_LEN`=65536, `NUM_LAGS`=16, `BUF_DEPTH`=256, `ACC_W`=48.
  - State enum `acdb_state_e`.
  - `sat32` function.
- **Sub-module `sample_ringbuf`:**
  - 256×16 circular buffer with asynchronous reset to 0.
  - One write port and one combinational read port addressed by lag offset.

## Test plan
- **Reset and idle:** assert `reset_ni`=0, then release → all outputs 0, `sample_ready_o`=1. A single sample 100 into the zero buffer → `sample_ready_o` is low for exactly 16 cycles and all accumulators remain 0.
- **DC frame, SHIFT=16:** 65536 samples of 256 → CLEAR cycle with `counter_o`=65536, then 16 results in order. Result k is `{k, 65536 − LAG[k]}`, and `frame_done_o` coincides with k=15.
- **Positive saturation, SHIFT=0:** constant 32767 for a frame → every value is 0x7FFF_FFFF.
- **Negative saturation, SHIFT=0:** alternating ±1000 for a frame → odd-lag values are 0x8000_0000.
- **Overrun:** `sample_valid_i` held high during MAC and DUMP → `overrun_o`=1 and stays 1. Dropped samples do not increment `counter_o`, and the frame still completes after 65536 accepted samples.
- **Mid-DUMP reset:** assert `reset_ni` low during DUMP k=5 → `db_valid_o` is 0 immediately and stays 0. After release, the next full DC frame reproduces the DC-frame results exactly, so no stale accumulation remains.
